// File: rtl/mesh_wormhole_ni_tx_pkg.sv
// Shared flit definitions for the mesh node, its virtual channels and the NI packetizers.
package mesh_wormhole_ni_tx_pkg;

  typedef enum logic [1:0] {
    FLIT_EMPTY  = 2'b00,
    FLIT_HEADER = 2'b01,
    FLIT_BODY   = 2'b10,
    FLIT_TAIL   = 2'b11
  } flit_id_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY
  } tx_state_e;

  // Header layout: dst_col in the LSBs, dst_row directly above it, rest zero.
  localparam int unsigned HDR_COL_LSB = 0;

  function automatic int unsigned flit_w(input int unsigned id_w, input int unsigned data_w);
    return id_w + data_w;
  endfunction

  function automatic int unsigned hdr_row_lsb(input int unsigned col_w);
    return HDR_COL_LSB + col_w;
  endfunction

endpackage

// File: rtl/mesh_wormhole_ni_tx_if.sv
// Message-in / flit-out channel bundle of the NI transmit packetizer.
interface mesh_wormhole_ni_tx_if
  import mesh_wormhole_ni_tx_pkg::*;
#(
  parameter int unsigned FLIT_DATA_W   = 8,
  parameter int unsigned FLIT_ID_W     = 2,
  parameter int unsigned ROW_ADDR_W    = 2,
  parameter int unsigned COL_ADDR_W    = 2,
  parameter int unsigned MAX_PAYLOAD_N = 4
);
  localparam int unsigned FLIT_W = flit_w(FLIT_ID_W, FLIT_DATA_W);
  localparam int unsigned LEN_W  = $clog2(MAX_PAYLOAD_N + 1);

  logic [MAX_PAYLOAD_N*FLIT_DATA_W-1:0] msg_data_i;
  logic [LEN_W-1:0]                     msg_len_i;
  logic [ROW_ADDR_W-1:0]                msg_dst_row_i;
  logic [COL_ADDR_W-1:0]                msg_dst_col_i;
  logic                                 msg_vld_i;
  logic                                 msg_rdy_o;
  logic [FLIT_W-1:0]                    out_data_o;
  logic                                 out_vld_o;
  logic                                 out_rdy_i;

  // master: the packetizer; slave: message source plus downstream node.
  modport master (
    input  msg_data_i, msg_len_i, msg_dst_row_i, msg_dst_col_i, msg_vld_i, out_rdy_i,
    output msg_rdy_o, out_data_o, out_vld_o
  );

  modport slave (
    output msg_data_i, msg_len_i, msg_dst_row_i, msg_dst_col_i, msg_vld_i, out_rdy_i,
    input  msg_rdy_o, out_data_o, out_vld_o
  );

endinterface

// File: rtl/mesh_wormhole_ni_tx.sv
// NI transmit packetizer: serializes one captured message into a HEADER/BODY.../TAIL worm.
module mesh_wormhole_ni_tx
  import mesh_wormhole_ni_tx_pkg::*;
#(
  parameter int unsigned FLIT_DATA_W   = 8,
  parameter int unsigned FLIT_ID_W     = 2,
  parameter int unsigned ROW_ADDR_W    = 2,
  parameter int unsigned COL_ADDR_W    = 2,
  parameter int unsigned MAX_PAYLOAD_N = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mesh_wormhole_ni_tx_if.master bus,
  output logic [CNT_W-1:0]      pkt_cnt_o
);
  localparam int unsigned LEN_W  = $clog2(MAX_PAYLOAD_N + 1);
  localparam int unsigned IDX_W  = (MAX_PAYLOAD_N > 1) ? $clog2(MAX_PAYLOAD_N) : 1;
  localparam int unsigned DATA_W = MAX_PAYLOAD_N * FLIT_DATA_W;

  tx_state_e               state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [DATA_W-1:0]       data_q;
  logic [ROW_ADDR_W-1:0]   row_q;
  logic [COL_ADDR_W-1:0]   col_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    accept;
  logic                    cnt_inc;
  logic                    is_tail;
  logic [FLIT_DATA_W-1:0]  hdr_data;
  logic [FLIT_DATA_W-1:0]  pay_data;

  // Length is stored as the index of the tail word, with 0 and oversize lengths clamped.
  always_comb begin
    last_d = '0;
    if (bus.msg_len_i == '0)
      last_d = '0;
    else if (bus.msg_len_i > LEN_W'(MAX_PAYLOAD_N))
      last_d = IDX_W'(MAX_PAYLOAD_N - 1);
    else
      last_d = IDX_W'(bus.msg_len_i - 1'b1);
  end

  always_comb begin
    hdr_data = '0;
    hdr_data[HDR_COL_LSB +: COL_ADDR_W]             = col_q;
    hdr_data[hdr_row_lsb(COL_ADDR_W) +: ROW_ADDR_W] = row_q;
  end

  assign pay_data = data_q[idx_q*FLIT_DATA_W +: FLIT_DATA_W];
  assign is_tail  = (idx_q == last_q);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    accept         = 1'b0;
    cnt_inc        = 1'b0;
    bus.msg_rdy_o  = 1'b0;
    bus.out_vld_o  = 1'b0;
    bus.out_data_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        bus.msg_rdy_o = 1'b1;
        accept        = bus.msg_vld_i;
        if (accept) state_d = ST_HDR;
      end
      ST_HDR: begin
        bus.out_data_o = {FLIT_ID_W'(FLIT_HEADER), hdr_data};
        bus.out_vld_o  = bus.out_rdy_i;
        if (bus.out_rdy_i) begin
          state_d = ST_PAY;
          idx_d   = '0;
        end
      end
      ST_PAY: begin
        bus.out_data_o = {is_tail ? FLIT_ID_W'(FLIT_TAIL) : FLIT_ID_W'(FLIT_BODY), pay_data};
        bus.out_vld_o  = bus.out_rdy_i;
        if (bus.out_rdy_i) begin
          if (is_tail) begin
            state_d = ST_IDLE;
            cnt_inc = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        data_q <= bus.msg_data_i;
        last_q <= last_d;
        row_q  <= bus.msg_dst_row_i;
        col_q  <= bus.msg_dst_col_i;
      end
      if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pkt_cnt_o = cnt_q;

endmodule

// File: tb/tb_mesh_wormhole_ni_tx.sv
// Directed and randomized bench for mesh_wormhole_ni_tx against a flit-queue reference model.
module tb_mesh_wormhole_ni_tx;
  import mesh_wormhole_ni_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pkt_cnt;
  bit          mon_on = 1'b0;

  always #5 clk = ~clk;

  mesh_wormhole_ni_tx_if #(
    .FLIT_DATA_W(8), .FLIT_ID_W(2), .ROW_ADDR_W(2), .COL_ADDR_W(2), .MAX_PAYLOAD_N(4)
  ) bus ();

  mesh_wormhole_ni_tx #(
    .FLIT_DATA_W(8), .FLIT_ID_W(2), .ROW_ADDR_W(2), .COL_ADDR_W(2),
    .MAX_PAYLOAD_N(4), .CNT_W(16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .pkt_cnt_o(pkt_cnt)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [9:0] exp_q[$];
  int         model_cnt = 0;
  logic [9:0] log_q[$];
  int         log_cyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a message becomes header + clamp(len,1,4) words, the last one typed TAIL.
  function automatic void push_pkt(input int row, input int col, input int len, input logic [31:0] data);
    int eff;
    eff = (len == 0) ? 1 : ((len > 4) ? 4 : len);
    exp_q.push_back(10'(256 + row * 4 + col));
    for (int k = 0; k < eff; k++)
      exp_q.push_back(10'(((k == eff - 1) ? 3 : 2) * 256 + int'((data >> (8 * k)) & 32'hFF)));
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      chk("msg_rdy", 32'(bus.msg_rdy_o), 32'(exp_q.size() == 0));
      chk("out_vld", 32'(bus.out_vld_o), 32'(exp_q.size() != 0 && bus.out_rdy_i));
      chk("out_data", 32'(bus.out_data_o), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      chk("pkt_cnt", 32'(pkt_cnt), 32'(model_cnt));
      if (bus.out_vld_o && exp_q.size() != 0) begin
        logic [9:0] f;
        f = exp_q.pop_front();
        log_q.push_back(bus.out_data_o);
        log_cyc.push_back(cyc);
        if (f[9:8] == 2'b11) model_cnt = (model_cnt + 1) % 65536;
      end
      if (rst) begin
        exp_q.delete();
        model_cnt = 0;
      end else if (bus.msg_vld_i && bus.msg_rdy_o) begin
        push_pkt(int'(bus.msg_dst_row_i), int'(bus.msg_dst_col_i), int'(bus.msg_len_i), bus.msg_data_i);
      end
    end
  end

  task automatic send(input int row, input int col, input int len, input logic [31:0] data);
    bit ok;
    ok = 1'b0;
    bus.msg_dst_row_i = 2'(row);
    bus.msg_dst_col_i = 2'(col);
    bus.msg_len_i     = 3'(len);
    bus.msg_data_i    = data;
    bus.msg_vld_i     = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.msg_rdy_o;
      @(posedge clk);
      #1;
    end
    bus.msg_vld_i = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 500 && !idle; i++) begin
      @(posedge clk);
      #1;
      idle = (exp_q.size() == 0);
    end
    chk("drain_timeout", 32'(idle), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  base;
    int  waited;
    bit  ok;
    bit  done6;
    bus.msg_data_i    = '0;
    bus.msg_len_i     = '0;
    bus.msg_dst_row_i = '0;
    bus.msg_dst_col_i = '0;
    bus.msg_vld_i     = 1'b0;
    bus.out_rdy_i     = 1'b1;

    // Reset state
    @(posedge clk); #1;
    mon_on = 1'b1;
    chk("rst_msg_rdy", 32'(bus.msg_rdy_o), 32'd1);
    chk("rst_out_vld", 32'(bus.out_vld_o), 32'd0);
    chk("rst_out_data", 32'(bus.out_data_o), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: basic packet, consecutive flits
    base = log_q.size();
    send(2, 3, 3, 32'h0033_2211);
    wait_done();
    chk("t1_count", 32'(log_q.size() - base), 32'd4);
    if (log_q.size() >= base + 4) begin
      chk("t1_hdr", 32'(log_q[base]), 32'h10B);
      chk("t1_b0", 32'(log_q[base+1]), 32'h211);
      chk("t1_b1", 32'(log_q[base+2]), 32'h222);
      chk("t1_tail", 32'(log_q[base+3]), 32'h333);
      chk("t1_span", 32'(log_cyc[base+3] - log_cyc[base]), 32'd3);
    end
    chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // 2: length clamping at both ends
    base = log_q.size();
    send(1, 0, 0, 32'h0000_00AA);
    wait_done();
    chk("t2a_count", 32'(log_q.size() - base), 32'd2);
    if (log_q.size() >= base + 2) begin
      chk("t2a_hdr", 32'(log_q[base]), 32'h104);
      chk("t2a_tail", 32'(log_q[base+1]), 32'h3AA);
    end
    base = log_q.size();
    send(0, 1, 7, 32'hDDCC_BBAA);
    wait_done();
    chk("t2b_count", 32'(log_q.size() - base), 32'd5);
    if (log_q.size() >= base + 5) begin
      chk("t2b_hdr", 32'(log_q[base]), 32'h101);
      chk("t2b_b2", 32'(log_q[base+3]), 32'h2CC);
      chk("t2b_tail", 32'(log_q[base+4]), 32'h3DD);
    end

    // 3: backpressure after the header
    base = log_q.size();
    send(3, 3, 2, 32'h0000_A55A);
    @(posedge clk); #1;
    bus.out_rdy_i = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("t3_hold_data", 32'(bus.out_data_o), 32'h25A);
    chk("t3_hold_vld", 32'(bus.out_vld_o), 32'd0);
    bus.out_rdy_i = 1'b1;
    wait_done();
    chk("t3_count", 32'(log_q.size() - base), 32'd3);
    if (log_q.size() >= base + 3) begin
      chk("t3_hdr", 32'(log_q[base]), 32'h10F);
      chk("t3_b0", 32'(log_q[base+1]), 32'h25A);
      chk("t3_tail", 32'(log_q[base+2]), 32'h3A5);
    end

    // 4: second message held valid during a packet
    base = log_q.size();
    send(0, 2, 2, 32'h0000_4433);
    bus.msg_dst_row_i = 2'd1;
    bus.msg_dst_col_i = 2'd1;
    bus.msg_len_i     = 3'd1;
    bus.msg_vld_i     = 1'b1;
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.msg_rdy_o;
      @(posedge clk); #1;
      if (!ok) begin
        waited++;
        bus.msg_data_i = $urandom;
      end
    end
    bus.msg_vld_i = 1'b0;
    chk("t4_accepted", 32'(ok), 32'd1);
    chk("t4_wait", 32'(waited), 32'd3);
    wait_done();
    chk("t4_count", 32'(log_q.size() - base), 32'd5);
    if (log_q.size() >= base + 5) begin
      chk("t4_a_tail", 32'(log_q[base+2]), 32'h344);
      chk("t4_b_hdr", 32'(log_q[base+3]), 32'h105);
      chk("t4_gap", 32'(log_cyc[base+3] - log_cyc[base+2]), 32'd2);
    end

    // 5: reset mid-payload
    send(1, 2, 3, 32'h0077_6655);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_out_vld", 32'(bus.out_vld_o), 32'd0);
    chk("t5_out_data", 32'(bus.out_data_o), 32'd0);
    chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("t5_msg_rdy", 32'(bus.msg_rdy_o), 32'd1);
    rst = 1'b0;

    // 6: random traffic under random backpressure
    done6 = 1'b0;
    fork
      begin
        for (int p = 0; p < 1000; p++)
          send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), $urandom);
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          bus.out_rdy_i = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        bus.out_rdy_i = 1'b1;
      end
    join
    wait_done();
    chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd1000);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mesh_wormhole_ni_tx.md
Name: mesh_wormhole_ni_tx

Overview:
- Network-interface transmit packetizer sitting directly upstream of a mesh wormhole node's local input channel.
- Accepts one message per handshake: destination row/col plus up to MAX_PAYLOAD_N payload words.
- Serializes the message into a wormhole packet: HEADER, then BODY flits, ending in a TAIL flit, under the node's ready backpressure.
- Keeps a running count of completed packets for debug and verification.

Parameters:
- FLIT_DATA_W, 8, payload bits per flit.
- FLIT_ID_W, 2, flit type field width; FLIT_W = FLIT_ID_W + FLIT_DATA_W, with the ID in the MSBs.
- ROW_ADDR_W, 2, destination row address width.
- COL_ADDR_W, 2, destination column address width. Requires ROW_ADDR_W + COL_ADDR_W <= FLIT_DATA_W.
- MAX_PAYLOAD_N, 4, maximum payload flits per packet (>= 1).
- CNT_W, 16, packet counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- msg_data_i  in  MAX_PAYLOAD_N*FLIT_DATA_W  payload words; word k is at bits [k*FLIT_DATA_W +: FLIT_DATA_W] and is sent k-th.
- msg_len_i  in  $clog2(MAX_PAYLOAD_N+1)  number of payload flits.
- msg_dst_row_i  in  ROW_ADDR_W  destination row.
- msg_dst_col_i  in  COL_ADDR_W  destination column.
- msg_vld_i  in  1  message valid.
- msg_rdy_o  out  1  message accept.
- out_data_o  out  FLIT_W  flit to the node input channel.
- out_vld_o  out  1  flit write strobe; it is itself the transfer event.
- out_rdy_i  in  1  node input FIFO not full.
- pkt_cnt_o  out  CNT_W  number of completed packets (tail flits transferred).

Behaviour:
- Flit IDs: EMPTY = 2'b00, HEADER = 2'b01, BODY = 2'b10, TAIL = 2'b11.
- Header data layout:
  - bits [COL_ADDR_W-1:0] = dst_col.
  - bits [COL_ADDR_W +: ROW_ADDR_W] = dst_row.
  - remaining bits = 0.
- Reset (rst_i sampled high at a clk_i edge):
  - state goes to IDLE; msg_rdy_o = 1; out_vld_o = 0; out_data_o = 0; pkt_cnt_o = 0; flit index = 0.
  - Reset wins over every other event in the same cycle.
- Message handshake:
  - accept occurs when msg_vld_i && msg_rdy_o.
  - msg_rdy_o = 1 only in IDLE (registered state, no combinational path from msg_vld_i).
  - On accept, data, length and destination are captured into internal registers; input changes afterwards have no effect.
- Length rules:
  - eff_len = 1 when msg_len_i == 0.
  - eff_len = MAX_PAYLOAD_N when msg_len_i > MAX_PAYLOAD_N.
  - otherwise eff_len = msg_len_i.
- Output handshake:
  - out_vld_o = flit_pending && out_rdy_i (combinational gating), so every out_vld_o pulse is exactly one accepted flit.
  - out_data_o holds the pending flit whenever state != IDLE, regardless of out_rdy_i; it is 0 in IDLE.
  - While out_rdy_i is low, the state, flit index and out_data_o stay constant.
- State machine:
  - IDLE -> HDR on accept.
  - HDR: presents the HEADER flit. On out_vld_o -> PAY with idx = 0.
  - PAY: presents word idx, typed TAIL if idx == eff_len-1, otherwise BODY.
    - On out_vld_o with a non-tail flit: idx++.
    - On out_vld_o with the tail flit: -> IDLE and pkt_cnt_o++.
- Latency:
  - accept at edge N; header presentable in cycle N+1.
  - With out_rdy_i held high, a packet takes 1+eff_len cycles, plus 1 IDLE cycle before the next message can be accepted.
- pkt_cnt_o wraps modulo 2^CNT_W.
- A reset mid-packet abandons the worm; the partial packet is not retransmitted and the counter is cleared. The integrating system must reset the whole mesh together.
- A destination equal to the local node's own coordinates is sent unmodified; routing is the node's concern.

Decomposition:
- Shared include/package holds:
  - flit ID constants (EMPTY/HEADER/BODY/TAIL).
  - FLIT_W and UNPACK macros.
  - header field offset macros.
  - These are common with the node, its virtual channels and the future ni_rx depacketizer.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
1. Reset release, dst row=2 col=3, len=3, data {0x33,0x22,0x11} (word0=0x11), out_rdy_i=1 -> flits 0x10B (HEADER), 0x211 (BODY), 0x222 (BODY), 0x333 (TAIL) on consecutive cycles; pkt_cnt_o=1.
2. len=0 with word0=0xAA -> HEADER, then single TAIL 0x3AA. len=7 -> header plus 4 payload flits, last one TAIL.
3. Backpressure: out_rdy_i low for 5 cycles after the header -> out_vld_o=0 and out_data_o stable for those cycles; flit order is unchanged after release; no flit is duplicated or lost.
4. msg_vld_i held high with changing data during a packet -> msg_rdy_o=0 until the tail transfers; the second message is accepted in the IDLE cycle afterwards and its header is not contiguous with the first tail.
5. rst_i asserted mid-PAY (after 1 body flit) -> next cycle IDLE, out_vld_o=0, pkt_cnt_o=0, msg_rdy_o=1.
6. Random lengths, random out_rdy_i, 1000 packets, with a scoreboard -> every packet is HEADER, (len-1) BODY, one TAIL; payload matches; pkt_cnt_o=1000.
